feature_sar_sequencer: RTL and testbench

FEATURE_SAR_SEQUENCER -- requirements
Module: feature_sar_sequencer

---
 rtl/feature_sar_sequencer.sv | 131 +++++++++++++
 tb/tb_feature_sar_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/feature_sar_sequencer.sv
// Frame sequencer that walks NUM_FEAT latched features through an MSB-first
// SAR resolution, presenting partial codes each cycle and a final code per feature.
module feature_sar_sequencer #(
    parameter int N          = 4,
    parameter int SAR_CYCLES = 5,
    parameter int NUM_FEAT   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_FEAT*N-1:0] feat_in,
    output logic [N-1:0]          quant_feat,
    output logic                  feat_valid,
    output logic [NUM_FEAT-1:0]   feat_sel,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state_dbg
);

    localparam int SW = (SAR_CYCLES > 1) ? $clog2(SAR_CYCLES) : 1;
    localparam int FW = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam logic [SW-1:0] SAR_LAST  = SW'(SAR_CYCLES - 1);
    localparam logic [FW-1:0] FEAT_LAST = FW'(NUM_FEAT - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Handshake: start is a level sampled only in IDLE; abort cancels any frame
    // on the next edge; outputs are registered copies of the next-state view.
    logic [1:0]            state, state_n;
    logic [SW-1:0]         sar_cnt, sar_n;
    logic [FW-1:0]         feat_cnt, feat_n;
    logic [NUM_FEAT*N-1:0] feat_lat, lat_n;
    logic [N-1:0]          cur_feat, code_n;
    logic [NUM_FEAT-1:0]   sel_n;
    logic                  valid_n;

    always_comb begin
        state_n = state;
        sar_n   = sar_cnt;
        feat_n  = feat_cnt;
        lat_n   = feat_lat;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = CONV;
                    sar_n   = '0;
                    feat_n  = '0;
                    lat_n   = feat_in;
                end
            end
            CONV: begin
                if (sar_cnt == SAR_LAST) begin
                    if (feat_cnt == FEAT_LAST) begin
                        state_n = DONE;
                    end else begin
                        sar_n  = '0;
                        feat_n = feat_cnt + 1'b1;
                    end
                end else begin
                    sar_n = sar_cnt + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                sar_n   = '0;
                feat_n  = '0;
                lat_n   = '0;
            end
            default: begin
                state_n = IDLE;
                sar_n   = '0;
                feat_n  = '0;
                lat_n   = '0;
            end
        endcase
        // Abort overrides everything, including a start presented in IDLE.
        if (abort) begin
            state_n = IDLE;
            sar_n   = '0;
            feat_n  = '0;
            lat_n   = '0;
        end
    end

    always_comb begin
        cur_feat = '0;
        sel_n    = '0;
        for (int k = 0; k < NUM_FEAT; k++) begin
            if (feat_n == FW'(k)) begin
                cur_feat = lat_n[k*N +: N];
                sel_n[k] = (state_n == CONV);
            end
        end
        // Bit b is resolved once sar_cnt reaches N-b; later counts hold the full code.
        code_n = '0;
        for (int b = 0; b < N; b++) begin
            code_n[b] = (state_n == CONV) && cur_feat[b] && (int'(sar_n) >= N - b);
        end
        valid_n = (state_n == CONV) && (sar_n == SAR_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            sar_cnt    <= '0;
            feat_cnt   <= '0;
            feat_lat   <= '0;
            quant_feat <= '0;
            feat_valid <= 1'b0;
            feat_sel   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            sar_cnt    <= sar_n;
            feat_cnt   <= feat_n;
            feat_lat   <= lat_n;
            quant_feat <= code_n;
            feat_valid <= valid_n;
            feat_sel   <= sel_n;
            busy       <= (state_n != IDLE);
            done       <= (state_n == DONE);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_feature_sar_sequencer.sv
// Bench for feature_sar_sequencer: a frame-position reference model predicts
// every output cycle; a negedge monitor pops and compares against the DUT.
module tb_feature_sar_sequencer;

    localparam int N  = 4;
    localparam int SC = 5;
    localparam int NF = 2;
    localparam int W  = N + NF + 3;
    localparam int FRAME = NF * SC;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [NF*N-1:0]   feat_in = '0;
    logic [N-1:0]      quant_feat;
    logic              feat_valid;
    logic [NF-1:0]     feat_sel;
    logic              busy;
    logic              done;
    logic [1:0]        state_dbg;

    logic [W-1:0]      exp_q[$];
    logic [N-1:0]      code_log[$];
    int                done_seen = 0;
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    string             phase = "reset";

    int                m_pos = 0;
    logic [NF*N-1:0]   m_vec = '0;

    feature_sar_sequencer #(.N(N), .SAR_CYCLES(SC), .NUM_FEAT(NF)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .feat_in(feat_in),
        .quant_feat(quant_feat), .feat_valid(feat_valid), .feat_sel(feat_sel),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        if (SC < N + 1) begin
            $display("FAIL param_check SAR_CYCLES=%0d required>=%0d", SC, N + 1);
            $fatal(1, "bad parameters");
        end
    end

    function automatic logic [W-1:0] pack(input logic [N-1:0] q, input logic v,
                                          input logic [NF-1:0] s, input logic b,
                                          input logic d);
        return {q, v, s, b, d};
    endfunction

    // Reference model: position within the frame (0 idle, 1..FRAME conv, FRAME+1 done).
    always @(posedge clk) begin
        int f, s, r, feat, code;
        logic [W-1:0] e;
        if (!rst || abort) begin
            m_pos = 0;
        end else if (m_pos == 0) begin
            if (start) begin
                m_pos = 1;
                m_vec = feat_in;
            end
        end else if (m_pos == FRAME + 1) begin
            m_pos = 0;
        end else begin
            m_pos = m_pos + 1;
        end
        if (m_pos >= 1 && m_pos <= FRAME) begin
            f    = (m_pos - 1) / SC;
            s    = (m_pos - 1) % SC;
            r    = (s < N) ? s : N;
            feat = (int'(m_vec) >> (f * N)) & ((1 << N) - 1);
            code = (feat >> (N - r)) << (N - r);
            e = pack(N'(code), s == SC - 1, NF'(1 << f), 1'b1, 1'b0);
        end else if (m_pos == FRAME + 1) begin
            e = pack('0, 1'b0, '0, 1'b1, 1'b1);
        end else begin
            e = '0;
        end
        exp_q.push_back(e);
    end

    // Monitor: one expected record per cycle.
    always @(negedge clk) begin
        logic [W-1:0] got, e;
        cyc = cyc + 1;
        if (feat_valid) code_log.push_back(quant_feat);
        if (done) done_seen = done_seen + 1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = pack(quant_feat, feat_valid, feat_sel, busy, done);
            checks = checks + 1;
            if (got !== e) begin
                errors = errors + 1;
                $display("FAIL trace[%s] cyc %0d got q=%b v=%b sel=%b busy=%b done=%b exp q=%b v=%b sel=%b busy=%b done=%b",
                         phase, cyc, quant_feat, feat_valid, feat_sel, busy, done,
                         e[W-1 -: N], e[NF+2], e[NF+1:2], e[1], e[0]);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        checks = checks + 1;
        if (got != want) begin
            errors = errors + 1;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic check_codes(input string name, input logic [N-1:0] c0, input logic [N-1:0] c1);
        logic [N-1:0] a, b;
        checks = checks + 1;
        if (code_log.size() != 2) begin
            errors = errors + 1;
            $display("FAIL %s got %0d final codes expected 2", name, code_log.size());
        end else begin
            a = code_log[0];
            b = code_log[1];
            if (a !== c0 || b !== c1) begin
                errors = errors + 1;
                $display("FAIL %s got %b,%b expected %b,%b", name, a, b, c0, c1);
            end
        end
        code_log.delete();
    endtask

    task automatic run_frame(input logic [NF*N-1:0] v);
        feat_in = v;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        start = 1'b1;
        feat_in = 8'h5A;
        tick(3);
        start = 1'b0;
        rst = 1'b1;
        tick(2);
        check("reset_no_start", done_seen, 0);

        phase = "nominal";
        done_seen = 0;
        code_log.delete();
        run_frame(8'b1010_0110);
        tick(FRAME + 3);
        check_codes("nominal_codes", 4'b0110, 4'b1010);
        check("nominal_done", done_seen, 1);

        phase = "feat_in_change";
        done_seen = 0;
        run_frame(8'b1010_0110);
        tick(2);
        feat_in = 8'hFF;
        tick(FRAME + 2);
        check_codes("latched_codes", 4'b0110, 4'b1010);
        check("latched_done", done_seen, 1);

        phase = "start_held";
        done_seen = 0;
        feat_in = 8'hC3;
        start = 1'b1;
        tick(20);
        start = 1'b0;
        tick(FRAME + 3);
        check("held_done", done_seen, 2);
        code_log.delete();

        phase = "abort";
        done_seen = 0;
        run_frame(8'h96);
        tick(5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick(FRAME + 2);
        check("abort_no_done", done_seen, 0);
        code_log.delete();
        run_frame(8'h3C);
        tick(FRAME + 3);
        check_codes("after_abort_codes", 4'b1100, 4'b0011);
        check("after_abort_done", done_seen, 1);

        phase = "mid_reset";
        done_seen = 0;
        run_frame(8'h7E);
        tick(2);
        rst = 1'b0;
        start = 1'b1;
        tick(3);
        start = 1'b0;
        rst = 1'b1;
        tick(FRAME + 2);
        check("mid_reset_no_done", done_seen, 0);

        phase = "abort_start_idle";
        feat_in = 8'h11;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick(FRAME + 2);
        check("abort_beats_start", done_seen, 0);

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            feat_in = NF*N'($urandom);
            start   = ($urandom_range(0, 3) == 0);
            abort   = ($urandom_range(0, 39) == 0);
            rst     = ($urandom_range(0, 79) != 0);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b1;
        tick(FRAME + 3);

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
